// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Sequences one external cartridge SRAM between the SNES bus and the MCU.
//   SNES requests always win arbitration; MCU accesses fill idle time and are
//   never preempted once started. Every access ends with a one-cycle RECOV
//   slot for bus turnaround.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   SNES_RD_STB/WR_STB      SNES access strobes (one-cycle pulses)
//   SNES_MAPPED_ADDR        decoded SRAM address for the SNES access
//   SNES_IS_WRITABLE        write gate from the address decoder
//   SNES_DIN / SNES_DOUT    SNES write data / last SNES read data
//   MCU_RRQ/WRQ             MCU request pulses, honoured only while idle
//   MCU_ADDR, MCU_DIN       MCU address / write data
//   MCU_DOUT                MCU read data
//   MCU_BUSY, MCU_RDY       MCU request outstanding / completion pulse
//   SRAM_*                  external SRAM address, data and strobes
module sram_arbiter #(
   parameter int unsigned RD_CYCLES = 6,
   parameter int unsigned WR_CYCLES = 6
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        SNES_RD_STB,
   input  logic        SNES_WR_STB,
   input  logic [23:0] SNES_MAPPED_ADDR,
   input  logic        SNES_IS_WRITABLE,
   input  logic [7:0]  SNES_DIN,
   output logic [7:0]  SNES_DOUT,
   input  logic        MCU_RRQ,
   input  logic        MCU_WRQ,
   input  logic [23:0] MCU_ADDR,
   input  logic [7:0]  MCU_DIN,
   output logic [7:0]  MCU_DOUT,
   output logic        MCU_BUSY,
   output logic        MCU_RDY,
   output logic [23:0] SRAM_ADDR,
   output logic [7:0]  SRAM_DQ_OUT,
   input  logic [7:0]  SRAM_DQ_IN,
   output logic        SRAM_DQ_OE,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N
);

   localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNES_RD,
      ST_SNES_WR,
      ST_MCU_RD,
      ST_MCU_WR,
      ST_RECOV
   } state_t;

   state_t            state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;

   logic              snes_pend_q,  snes_pend_d;
   logic              snes_is_wr_q, snes_is_wr_d;
   logic [23:0]       snes_addr_q,  snes_addr_d;
   logic [7:0]        snes_data_q,  snes_data_d;

   logic              mcu_pend_q,   mcu_pend_d;
   logic              mcu_is_wr_q,  mcu_is_wr_d;
   logic [23:0]       mcu_addr_q,   mcu_addr_d;
   logic [7:0]        mcu_data_q,   mcu_data_d;
   logic              mcu_busy_q,   mcu_busy_d;
   logic              mcu_rdy_q,    mcu_rdy_d;

   logic [7:0]        snes_dout_q,  snes_dout_d;
   logic [7:0]        mcu_dout_q,   mcu_dout_d;
   logic [23:0]       sram_addr_q,  sram_addr_d;
   logic [7:0]        sram_dq_out_q, sram_dq_out_d;

   logic              mcu_accept;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         snes_pend_q   <= 1'b0;
         snes_is_wr_q  <= 1'b0;
         snes_addr_q   <= '0;
         snes_data_q   <= '0;
         mcu_pend_q    <= 1'b0;
         mcu_is_wr_q   <= 1'b0;
         mcu_addr_q    <= '0;
         mcu_data_q    <= '0;
         mcu_busy_q    <= 1'b0;
         mcu_rdy_q     <= 1'b0;
         snes_dout_q   <= '0;
         mcu_dout_q    <= '0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         snes_pend_q   <= snes_pend_d;
         snes_is_wr_q  <= snes_is_wr_d;
         snes_addr_q   <= snes_addr_d;
         snes_data_q   <= snes_data_d;
         mcu_pend_q    <= mcu_pend_d;
         mcu_is_wr_q   <= mcu_is_wr_d;
         mcu_addr_q    <= mcu_addr_d;
         mcu_data_q    <= mcu_data_d;
         mcu_busy_q    <= mcu_busy_d;
         mcu_rdy_q     <= mcu_rdy_d;
         snes_dout_q   <= snes_dout_d;
         mcu_dout_q    <= mcu_dout_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      snes_pend_d   = snes_pend_q;
      snes_is_wr_d  = snes_is_wr_q;
      snes_addr_d   = snes_addr_q;
      snes_data_d   = snes_data_q;
      mcu_pend_d    = mcu_pend_q;
      mcu_is_wr_d   = mcu_is_wr_q;
      mcu_addr_d    = mcu_addr_q;
      mcu_data_d    = mcu_data_q;
      mcu_busy_d    = mcu_busy_q;
      mcu_rdy_d     = 1'b0;
      snes_dout_d   = snes_dout_q;
      mcu_dout_d    = mcu_dout_q;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;

      // A single SNES request slot: the latest strobe replaces whatever is
      // pending, and a read strobe shadows a simultaneous write strobe.
      if (SNES_RD_STB) begin
         snes_pend_d  = 1'b1;
         snes_is_wr_d = 1'b0;
         snes_addr_d  = SNES_MAPPED_ADDR;
      end else if (SNES_WR_STB && SNES_IS_WRITABLE) begin
         snes_pend_d  = 1'b1;
         snes_is_wr_d = 1'b1;
         snes_addr_d  = SNES_MAPPED_ADDR;
         snes_data_d  = SNES_DIN;
      end

      mcu_accept = !mcu_busy_q && (MCU_RRQ || MCU_WRQ);
      if (mcu_accept) begin
         mcu_pend_d  = 1'b1;
         mcu_is_wr_d = !MCU_RRQ;
         mcu_addr_d  = MCU_ADDR;
         mcu_data_d  = MCU_DIN;
         mcu_busy_d  = 1'b1;
      end

      // IDLE arbitrates on the post-capture request set, so a strobe seen
      // in IDLE is granted on the same edge that captures it.
      unique case (state_q)
         ST_IDLE: begin
            if (snes_pend_d) begin
               state_d     = snes_is_wr_d ? ST_SNES_WR : ST_SNES_RD;
               cnt_d       = '0;
               snes_pend_d = 1'b0;
               sram_addr_d = snes_addr_d;
               if (snes_is_wr_d) begin
                  sram_dq_out_d = snes_data_d;
               end
            end else if (mcu_pend_d) begin
               state_d     = mcu_is_wr_d ? ST_MCU_WR : ST_MCU_RD;
               cnt_d       = '0;
               mcu_pend_d  = 1'b0;
               sram_addr_d = mcu_addr_d;
               if (mcu_is_wr_d) begin
                  sram_dq_out_d = mcu_data_d;
               end
            end
         end
         ST_SNES_RD: begin
            if (cnt_q == RD_LAST) begin
               snes_dout_d = SRAM_DQ_IN;
               state_d     = ST_RECOV;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_MCU_RD: begin
            if (cnt_q == RD_LAST) begin
               mcu_dout_d = SRAM_DQ_IN;
               mcu_busy_d = 1'b0;
               mcu_rdy_d  = 1'b1;
               state_d    = ST_RECOV;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SNES_WR: begin
            if (cnt_q == WR_LAST) begin
               state_d = ST_RECOV;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_MCU_WR: begin
            if (cnt_q == WR_LAST) begin
               mcu_busy_d = 1'b0;
               mcu_rdy_d  = 1'b1;
               state_d    = ST_RECOV;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RECOV: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Strobes decode straight from the state register so an asynchronous
   // reset releases the bus in the same instant it is asserted.
   logic rd_state;
   logic wr_state;

   always_comb begin
      rd_state = (state_q == ST_SNES_RD) || (state_q == ST_MCU_RD);
      wr_state = (state_q == ST_SNES_WR) || (state_q == ST_MCU_WR);
   end

   assign SRAM_OE_N   = !rd_state;
   assign SRAM_DQ_OE  = wr_state;
   // First write cycle is address/data setup, last is hold.
   assign SRAM_WE_N   = !(wr_state && (cnt_q != '0) && (cnt_q != WR_LAST));
   assign SRAM_ADDR   = sram_addr_q;
   assign SRAM_DQ_OUT = sram_dq_out_q;
   assign SNES_DOUT   = snes_dout_q;
   assign MCU_DOUT    = mcu_dout_q;
   assign MCU_BUSY    = mcu_busy_q;
   assign MCU_RDY     = mcu_rdy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a small SRAM model keyed on the low
//   address byte. Bus invariants are watched on every falling edge.
module tb_sram_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        SNES_RD_STB = 1'b0;
   logic        SNES_WR_STB = 1'b0;
   logic [23:0] SNES_MAPPED_ADDR = '0;
   logic        SNES_IS_WRITABLE = 1'b0;
   logic [7:0]  SNES_DIN = '0;
   logic [7:0]  SNES_DOUT;
   logic        MCU_RRQ = 1'b0;
   logic        MCU_WRQ = 1'b0;
   logic [23:0] MCU_ADDR = '0;
   logic [7:0]  MCU_DIN = '0;
   logic [7:0]  MCU_DOUT;
   logic        MCU_BUSY;
   logic        MCU_RDY;
   logic [23:0] SRAM_ADDR;
   logic [7:0]  SRAM_DQ_OUT;
   logic [7:0]  SRAM_DQ_IN;
   logic        SRAM_DQ_OE;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;

   int total = 0;
   int bad   = 0;

   sram_arbiter #(.RD_CYCLES(6), .WR_CYCLES(6)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .SNES_RD_STB(SNES_RD_STB), .SNES_WR_STB(SNES_WR_STB),
      .SNES_MAPPED_ADDR(SNES_MAPPED_ADDR), .SNES_IS_WRITABLE(SNES_IS_WRITABLE),
      .SNES_DIN(SNES_DIN), .SNES_DOUT(SNES_DOUT),
      .MCU_RRQ(MCU_RRQ), .MCU_WRQ(MCU_WRQ), .MCU_ADDR(MCU_ADDR),
      .MCU_DIN(MCU_DIN), .MCU_DOUT(MCU_DOUT), .MCU_BUSY(MCU_BUSY), .MCU_RDY(MCU_RDY),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_IN(SRAM_DQ_IN),
      .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
   );

   always #5 CLK = ~CLK;

   // SRAM model: 256 bytes indexed by the low address byte.
   logic [7:0] mem [0:255];
   logic       pre_we = 1'b0;
   logic [7:0] pre_a  = '0;
   logic [7:0] pre_d  = '0;

   always @(posedge CLK) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (RST_N && !SRAM_WE_N && SRAM_DQ_OE) mem[SRAM_ADDR[7:0]] <= SRAM_DQ_OUT;
   end

   assign SRAM_DQ_IN = SRAM_OE_N ? 8'h00 : mem[SRAM_ADDR[7:0]];

   always @(negedge CLK) begin
      if (RST_N) begin
         total++;
         if (!SRAM_OE_N && !SRAM_WE_N) begin
            bad++;
            $display("FAIL oe_we_excl: OE_N=%b WE_N=%b both low at %0t", SRAM_OE_N, SRAM_WE_N, $time);
         end
         total++;
         if (SRAM_DQ_OE && !SRAM_OE_N) begin
            bad++;
            $display("FAIL dqoe_oe_excl: DQ_OE=%b OE_N=%b at %0t", SRAM_DQ_OE, SRAM_OE_N, $time);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      step();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) step();
      total++; if (SRAM_OE_N !== 1'b1) begin bad++; $display("FAIL rst_oe_n: got %b want 1", SRAM_OE_N); end
      total++; if (SRAM_WE_N !== 1'b1) begin bad++; $display("FAIL rst_we_n: got %b want 1", SRAM_WE_N); end
      total++; if (SRAM_DQ_OE !== 1'b0) begin bad++; $display("FAIL rst_dq_oe: got %b want 0", SRAM_DQ_OE); end
      total++; if (MCU_BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", MCU_BUSY); end
      total++; if (MCU_RDY !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", MCU_RDY); end
      total++; if (SRAM_ADDR !== 24'h0) begin bad++; $display("FAIL rst_addr: got %h want 000000", SRAM_ADDR); end
      total++; if (SNES_DOUT !== 8'h0 || MCU_DOUT !== 8'h0) begin
         bad++; $display("FAIL rst_dout: snes=%h mcu=%h want 00/00", SNES_DOUT, MCU_DOUT);
      end
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_snes_read();
      int oe_lo, first_oe, bad_addr;
      preload(8'h56, 8'hA5);
      SNES_MAPPED_ADDR = 24'h123456;
      SNES_RD_STB = 1'b1;
      step();
      SNES_RD_STB = 1'b0;
      oe_lo = 0; first_oe = -1; bad_addr = 0;
      for (int i = 0; i < 10; i++) begin
         if (!SRAM_OE_N) begin
            oe_lo++;
            if (first_oe < 0) first_oe = i;
            if (SRAM_ADDR !== 24'h123456) bad_addr++;
         end
         if (i == 6) begin
            total++;
            if (SNES_DOUT !== 8'hA5) begin bad++; $display("FAIL snes_rd_data: got %h want a5", SNES_DOUT); end
            total++;
            if (SRAM_OE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin
               bad++; $display("FAIL snes_rd_recov: OE_N=%b DQ_OE=%b want 1/0", SRAM_OE_N, SRAM_DQ_OE);
            end
         end
         step();
      end
      total++; if (oe_lo != 6) begin bad++; $display("FAIL snes_rd_oe_len: got %0d want 6", oe_lo); end
      total++; if (first_oe != 0) begin bad++; $display("FAIL snes_rd_latency: got %0d want 0", first_oe); end
      total++; if (bad_addr != 0) begin bad++; $display("FAIL snes_rd_addr: %0d bad cycles want 0", bad_addr); end
   endtask

   task automatic test_snes_write(input logic w, input logic [7:0] d, input logic [7:0] exp_mem);
      int we_lo, dq_hi, first_we, bad_dat, exp_we, exp_dq, exp_first;
      SNES_MAPPED_ADDR = 24'hE00010;
      SNES_DIN = d;
      SNES_IS_WRITABLE = w;
      SNES_WR_STB = 1'b1;
      step();
      SNES_WR_STB = 1'b0;
      SNES_IS_WRITABLE = 1'b0;
      we_lo = 0; dq_hi = 0; first_we = -1; bad_dat = 0;
      for (int i = 0; i < 10; i++) begin
         if (!SRAM_WE_N) begin
            we_lo++;
            if (first_we < 0) first_we = i;
         end
         if (SRAM_DQ_OE) begin
            dq_hi++;
            if (SRAM_DQ_OUT !== d || SRAM_ADDR !== 24'hE00010) bad_dat++;
         end
         step();
      end
      exp_we = w ? 4 : 0;
      exp_dq = w ? 6 : 0;
      exp_first = w ? 1 : -1;
      total++; if (we_lo != exp_we) begin bad++; $display("FAIL snes_wr_we_len(w=%b): got %0d want %0d", w, we_lo, exp_we); end
      total++; if (dq_hi != exp_dq) begin bad++; $display("FAIL snes_wr_dqoe_len(w=%b): got %0d want %0d", w, dq_hi, exp_dq); end
      total++; if (first_we != exp_first) begin bad++; $display("FAIL snes_wr_setup(w=%b): got %0d want %0d", w, first_we, exp_first); end
      total++; if (bad_dat != 0) begin bad++; $display("FAIL snes_wr_data_stable(w=%b): %0d bad cycles want 0", w, bad_dat); end
      total++; if (mem[8'h10] !== exp_mem) begin bad++; $display("FAIL snes_wr_mem(w=%b): got %h want %h", w, mem[8'h10], exp_mem); end
   endtask

   task automatic test_mcu_write_read();
      int n, oe_lo, rdy_cnt;
      MCU_ADDR = 24'h000200; MCU_DIN = 8'h77; MCU_WRQ = 1'b1;
      step();
      MCU_WRQ = 1'b0;
      total++; if (MCU_BUSY !== 1'b1) begin bad++; $display("FAIL mcu_wr_busy: got %b want 1", MCU_BUSY); end
      n = 0;
      while (MCU_RDY !== 1'b1 && n < 20) begin step(); n++; end
      total++; if (n != 6) begin bad++; $display("FAIL mcu_wr_rdy_time: got %0d want 6", n); end
      total++; if (MCU_BUSY !== 1'b0) begin bad++; $display("FAIL mcu_wr_busy_fall: got %b want 0", MCU_BUSY); end
      step();
      total++; if (MCU_RDY !== 1'b0) begin bad++; $display("FAIL mcu_wr_rdy_pulse: got %b want 0", MCU_RDY); end
      total++; if (mem[8'h00] !== 8'h77) begin bad++; $display("FAIL mcu_wr_mem: got %h want 77", mem[8'h00]); end
      step();

      MCU_ADDR = 24'h000200; MCU_RRQ = 1'b1;
      step();
      // second request while busy: must be dropped
      MCU_ADDR = 24'h123456;
      step();
      MCU_RRQ = 1'b0;
      n = 0;
      while (MCU_RDY !== 1'b1 && n < 20) begin step(); n++; end
      total++; if (n != 5) begin bad++; $display("FAIL mcu_rd_rdy_time: got %0d want 5", n); end
      total++; if (MCU_DOUT !== 8'h77) begin bad++; $display("FAIL mcu_rd_data: got %h want 77", MCU_DOUT); end
      total++; if (MCU_BUSY !== 1'b0) begin bad++; $display("FAIL mcu_rd_busy_fall: got %b want 0", MCU_BUSY); end
      step();
      total++; if (MCU_RDY !== 1'b0) begin bad++; $display("FAIL mcu_rd_rdy_pulse: got %b want 0", MCU_RDY); end
      oe_lo = 0; rdy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (!SRAM_OE_N) oe_lo++;
         if (MCU_RDY) rdy_cnt++;
         step();
      end
      total++; if (oe_lo != 0 || rdy_cnt != 0) begin
         bad++; $display("FAIL mcu_busy_ignore: oe_cycles=%0d rdy=%0d want 0/0", oe_lo, rdy_cnt);
      end
   endtask

   task automatic test_collision();
      int n, rdy_at, snes_at;
      MCU_ADDR = 24'h000200; MCU_RRQ = 1'b1;
      step();
      MCU_RRQ = 1'b0;
      step();
      step();
      // MCU read is now in its cycle 2; strobe sampled at the end of it
      SNES_MAPPED_ADDR = 24'h123456; SNES_RD_STB = 1'b1;
      step();
      SNES_RD_STB = 1'b0;
      rdy_at = -1; snes_at = -1; n = 0;
      while (snes_at < 0 && n < 20) begin
         if (MCU_RDY && rdy_at < 0) rdy_at = n;
         if (!SRAM_OE_N && SRAM_ADDR === 24'h123456) snes_at = n;
         else begin step(); n++; end
      end
      total++; if (rdy_at != 3) begin bad++; $display("FAIL coll_mcu_rdy: got %0d want 3", rdy_at); end
      total++; if (MCU_DOUT !== 8'h77) begin bad++; $display("FAIL coll_mcu_data: got %h want 77", MCU_DOUT); end
      total++; if (snes_at != 5) begin bad++; $display("FAIL coll_snes_wait: got %0d want 5", snes_at); end
      repeat (6) step();
      total++; if (SNES_DOUT !== 8'hA5) begin bad++; $display("FAIL coll_snes_data: got %h want a5", SNES_DOUT); end
      step();

      // SNES strobe and MCU request in the same idle cycle
      preload(8'h56, 8'h5A);
      preload(8'h00, 8'h3E);
      SNES_MAPPED_ADDR = 24'h123456; SNES_RD_STB = 1'b1;
      MCU_ADDR = 24'h000200; MCU_RRQ = 1'b1;
      step();
      SNES_RD_STB = 1'b0; MCU_RRQ = 1'b0;
      total++; if (SRAM_OE_N !== 1'b0 || SRAM_ADDR !== 24'h123456) begin
         bad++; $display("FAIL same_snes_first: OE_N=%b addr=%h want 0/123456", SRAM_OE_N, SRAM_ADDR);
      end
      total++; if (MCU_BUSY !== 1'b1) begin bad++; $display("FAIL same_mcu_busy: got %b want 1", MCU_BUSY); end
      rdy_at = -1; snes_at = -1;
      for (int i = 0; i < 20; i++) begin
         if (snes_at < 0 && !SRAM_OE_N && SRAM_ADDR === 24'h000200) snes_at = i;
         if (rdy_at < 0 && MCU_RDY) rdy_at = i;
         step();
      end
      total++; if (snes_at != 8) begin bad++; $display("FAIL same_mcu_start: got %0d want 8", snes_at); end
      total++; if (rdy_at != 14) begin bad++; $display("FAIL same_mcu_rdy: got %0d want 14", rdy_at); end
      total++; if (SNES_DOUT !== 8'h5A || MCU_DOUT !== 8'h3E) begin
         bad++; $display("FAIL same_data: snes=%h mcu=%h want 5a/3e", SNES_DOUT, MCU_DOUT);
      end
   endtask

   task automatic test_simul_strobes();
      int oe_lo, we_lo, dq_hi;
      preload(8'h56, 8'hC7);
      SNES_MAPPED_ADDR = 24'h123456; SNES_DIN = 8'h99; SNES_IS_WRITABLE = 1'b1;
      SNES_RD_STB = 1'b1; SNES_WR_STB = 1'b1;
      step();
      SNES_RD_STB = 1'b0; SNES_WR_STB = 1'b0; SNES_IS_WRITABLE = 1'b0;
      oe_lo = 0; we_lo = 0; dq_hi = 0;
      for (int i = 0; i < 12; i++) begin
         if (!SRAM_OE_N) oe_lo++;
         if (!SRAM_WE_N) we_lo++;
         if (SRAM_DQ_OE) dq_hi++;
         step();
      end
      total++; if (oe_lo != 6) begin bad++; $display("FAIL simul_oe_len: got %0d want 6", oe_lo); end
      total++; if (we_lo != 0 || dq_hi != 0) begin bad++; $display("FAIL simul_no_write: we=%0d dqoe=%0d want 0/0", we_lo, dq_hi); end
      total++; if (SNES_DOUT !== 8'hC7) begin bad++; $display("FAIL simul_data: got %h want c7", SNES_DOUT); end
   endtask

   task automatic test_reset_mid_access();
      int rdy_cnt, oe_lo;
      MCU_ADDR = 24'h000200; MCU_RRQ = 1'b1;
      step();
      MCU_RRQ = 1'b0;
      step();
      total++; if (SRAM_OE_N !== 1'b0) begin bad++; $display("FAIL midrst_pre_oe: got %b want 0", SRAM_OE_N); end
      RST_N = 1'b0;
      #1;
      total++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_DQ_OE !== 1'b0) begin
         bad++; $display("FAIL midrst_bus: OE_N=%b WE_N=%b DQ_OE=%b want 1/1/0", SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE);
      end
      total++; if (MCU_BUSY !== 1'b0 || SRAM_ADDR !== 24'h0) begin
         bad++; $display("FAIL midrst_state: busy=%b addr=%h want 0/000000", MCU_BUSY, SRAM_ADDR);
      end
      step();
      step();
      RST_N = 1'b1;
      rdy_cnt = 0; oe_lo = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (MCU_RDY) rdy_cnt++;
         if (!SRAM_OE_N) oe_lo++;
      end
      total++; if (rdy_cnt != 0 || oe_lo != 0) begin
         bad++; $display("FAIL midrst_no_rdy: rdy=%0d oe_cycles=%0d want 0/0", rdy_cnt, oe_lo);
      end
   endtask

   initial begin
      test_reset();
      test_snes_read();
      test_snes_write(1'b1, 8'h3C, 8'h3C);
      test_snes_write(1'b0, 8'hC3, 8'h3C);
      test_mcu_write_read();
      test_collision();
      test_simul_strobes();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the single external cartridge SRAM (ROM/SaveRAM/BS-X PSRAM) between two requesters: the SNES bus (address already mapped by the address decoder) and the MCU (load/save/DMA port).
- Generates SRAM OE/WE/data-drive timing, captures read data, and returns it to each requester.
- SNES accesses are timing-critical and always have priority. MCU accesses are slotted into idle time.

Parameters:
- RD_CYCLES, 6, clock cycles OE_N is held low per read (min 2).
- WR_CYCLES, 6, clock cycles per write including 1 setup and 1 hold cycle (min 3).

Ports:
- CLK  in  1  system clock; sole clock.
- RST_N  in  1  asynchronous active-low reset.
- SNES_RD_STB  in  1  one-cycle pulse: SNES read cycle begins.
- SNES_WR_STB  in  1  one-cycle pulse: SNES write data valid.
- SNES_MAPPED_ADDR  in  24  mapped SRAM address from the address decoder.
- SNES_IS_WRITABLE  in  1  decoder: current address is writable.
- SNES_DIN  in  8  SNES write data.
- SNES_DOUT  out  8  last SNES read data (registered).
- MCU_RRQ  in  1  MCU read request pulse.
- MCU_WRQ  in  1  MCU write request pulse.
- MCU_ADDR  in  24  MCU address.
- MCU_DIN  in  8  MCU write data.
- MCU_DOUT  out  8  MCU read data (registered).
- MCU_BUSY  out  1  MCU request accepted and not yet complete.
- MCU_RDY  out  1  one-cycle pulse: MCU access complete.
- SRAM_ADDR  out  24  SRAM address.
- SRAM_DQ_OUT  out  8  SRAM write data.
- SRAM_DQ_IN  in  8  SRAM read data.
- SRAM_DQ_OE  out  1  drive data bus.
- SRAM_OE_N  out  1  SRAM output enable, active low.
- SRAM_WE_N  out  1  SRAM write enable, active low.

Behaviour:

Clock and reset:
- Single clock CLK. Reset is asynchronous, active-low on RST_N.
- Reset values: SRAM_OE_N=1, SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SNES_DOUT=0, MCU_DOUT=0, MCU_BUSY=0, MCU_RDY=0.
- State returns to IDLE and all pending flags and counters clear.
- Reset asserted mid-access aborts the access immediately; no RDY pulse is generated for it.

Request capture:
- SNES_RD_STB sets snes_rd_pend and latches SNES_MAPPED_ADDR.
- SNES_WR_STB sets snes_wr_pend only if SNES_IS_WRITABLE=1, latching address and SNES_DIN. Otherwise the write is discarded and no SRAM cycle occurs.
- If both SNES strobes arrive in the same cycle, the read is taken and the write is discarded.
- A new SNES strobe while a SNES request is pending overwrites it (last wins).
- MCU requests are accepted only while MCU_BUSY=0. Acceptance latches address and data and sets MCU_BUSY on the next edge.
- If MCU_RRQ and MCU_WRQ arrive together, the read is accepted and the write is ignored.
- Requests arriving while MCU_BUSY=1 are ignored.

State machine (IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR, RECOV):
- IDLE grant priority: snes_rd_pend > snes_wr_pend > MCU read > MCU write.
- A strobe that arrives while in IDLE is granted at the same edge it is captured. Example: OE_N goes low in the cycle after the strobe is sampled, giving SNES read latency of 1 cycle to OE.
- SNES_RD / MCU_RD:
  - SRAM_ADDR is driven from the latched address.
  - SRAM_OE_N=0 for exactly RD_CYCLES cycles.
  - SRAM_DQ_IN is captured into SNES_DOUT or MCU_DOUT at the edge ending the last cycle.
  - Next state is RECOV.
- SNES_WR / MCU_WR, WR_CYCLES cycles total:
  - SRAM_DQ_OE=1 throughout.
  - Cycle 0: WE_N=1 (setup).
  - Cycles 1..WR_CYCLES-2: WE_N=0.
  - Last cycle: WE_N=1 (hold).
  - Address and data are stable throughout. Next state is RECOV.
- RECOV: one cycle with OE_N=1, WE_N=1, DQ_OE=0 (bus turnaround); then IDLE.
- An MCU access is never preempted. A SNES strobe arriving during it stays pending and is granted from the IDLE following RECOV.
- SRAM_ADDR holds its last value in IDLE/RECOV. The cycle counter is sized for max(RD_CYCLES, WR_CYCLES).

MCU completion:
- MCU_RDY pulses for 1 cycle, and MCU_BUSY falls, on the edge that enters RECOV from an MCU state.
- MCU_DOUT is valid from that same edge.

Invariants:
- OE_N=0 and WE_N=0 never occur together.
- DQ_OE=1 never coincides with OE_N=0.

Test Plan:
- Reset then idle: RST_N low for 3 cycles → OE_N=1, WE_N=1, DQ_OE=0, MCU_BUSY=0. Assert RST_N low mid-MCU_RD → outputs return to idle values immediately and no MCU_RDY follows.
- SNES read, RD_CYCLES=6: strobe with mapped addr 0x123456, SRAM returns 0xA5 → SRAM_ADDR=0x123456 and OE_N low for exactly 6 cycles starting 1 cycle after the strobe; SNES_DOUT=0xA5; then 1 RECOV cycle.
- SNES write gating: write strobe, addr 0xE00010, data 0x3C, IS_WRITABLE=1 → WE_N low for 4 cycles, DQ_OUT=0x3C. Repeat with IS_WRITABLE=0 → no WE_N activity.
- MCU write then read: MCU_WRQ to 0x000200 with 0x77, wait for RDY; MCU_RRQ to 0x000200 with a bench memory model → MCU_DOUT=0x77, each RDY is a 1-cycle pulse, BUSY falls with RDY. A second MCU_RRQ issued while BUSY=1 is ignored.
- Collision: MCU_RD in progress (cycle 2 of 6) when SNES_RD_STB arrives → MCU read completes untouched, RECOV, then SNES_RD starts; total SNES wait = 4 + 1 + 1 cycles. SNES strobe and MCU_RRQ in the same IDLE cycle → SNES served first, MCU read follows after RECOV.
- Simultaneous SNES strobes: RD and WR strobes in the same cycle → only the read executes and WE_N stays high. Across all tests the assertion monitor checks OE_N/WE_N exclusivity and DQ_OE/OE_N exclusivity.
